hypercord_stage_sched: RTL and testbench
========================================

// Module: hypercord_stage_sched
// PURPOSE
//  Sequencer that time-multiplexes one combinational hyperbolic-CORDIC stage datapath over NUM_STAGES passes per operand.
//  Accepts (X,Y,Z,tag) on a valid/ready slave port and presents the working vector plus stage select to the datapath each cycle.
//  Latches the datapath result each cycle and returns the final (X,Y,tag) on a valid/ready master port.
//  Sits between the operand source and the shared stage mux (stage1..stage4 behind dp_sel).
// PARAMETERS
//  DWIDTH      IDWIDTH  datapath word width, from hyperCord_pkg
//  NUM_STAGES  4        stage passes per operand, 1..8
//  TAGW        4        opaque tag width carried with each operand
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  rst_n        in   1                   asynchronous active-low reset
//  s_valid      in   1                   operand valid
//  s_ready      out  1                   operand accepted when s_valid&&s_ready
//  s_x/s_y/s_z  in   DWIDTH              operand vector
//  s_tag        in   TAGW                operand tag
//  cfg_stage_en in   NUM_STAGES          per-stage enable, sampled at accept
//  dp_sel       out  $clog2(NUM_STAGES)  stage index driven to datapath
//  dp_xin/dp_yin/dp_zin out DWIDTH       working vector to datapath
//  dp_xout/dp_yout/dp_zout in DWIDTH     datapath result, combinational from dp_*in
//  m_valid      out  1                   result valid
//  m_ready      in   1                   result consumer ready
//  m_x/m_y      out  DWIDTH              result vector
//  m_tag        out  TAGW                result tag
//  busy         out  1                   state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, s_ready=0 during reset then 1, m_valid=0, busy=0, dp_sel=0, all data regs 0.
//  - FSM: IDLE -> RUN on accept with >=1 enabled stage; IDLE -> DONE on accept with cfg_stage_en==0.
//    RUN -> DONE after last enabled stage; DONE -> IDLE on m_ready with no new accept.
//    DONE -> RUN/DONE on m_ready with simultaneous accept.
//  - s_ready = (state==IDLE) | (state==DONE & m_ready); combinational, no dependence on s_valid.
//  - Accept edge: load x/y/z/tag regs and en_mask=cfg_stage_en; stage_ptr = lowest set bit of en_mask.
//  - RUN cycle: dp_sel=stage_ptr; dp_*in = working regs.
//    On edge: x<=dp_xout, y<=dp_yout, z<=dp_zout, except on the final stage index NUM_STAGES-1 (z held; last stage emits no Z).
//    Clear en_mask[stage_ptr]; stage_ptr = next set bit; if none remain -> DONE.
//  - Disabled stages consume no cycle. Latency: m_valid rises popcount(en)+1 edges after accept edge, minimum 1 (all disabled: input passes through unchanged).
//  - DONE: m_valid=1, m_x/m_y/m_tag stable until m_valid&&m_ready; no output change while stalled.
//  - Back-to-back: handshake out and accept in same cycle -> no idle bubble; new operand loads, old result retires.
//  - dp_sel/dp_*in outside RUN: dp_sel=0, dp_*in = working regs (don't-care to datapath, but deterministic).
//  - cfg_stage_en changes outside accept cycle: ignored for the in-flight operand.
//  - Arithmetic: none local; widths pass-through, no truncation or extension.
//  - Reset mid-RUN or mid-DONE: operand and result discarded, m_valid drops asynchronously, no partial output.
// STRUCTURE
//  - hyperCord_pkg additions:
//      typedef enum logic [1:0] {SCHED_IDLE, SCHED_RUN, SCHED_DONE} sched_state_t;
//      localparam HC_NUM_STAGES = 4;
//      function first_set(mask) returning the lowest set index.
//  - Sub-module: hypercord_stage_ptr (priority encoder: mask -> next index + none flag), reused for accept and advance.
//  - FSM, working regs, handshake logic inline in this module.
// TESTING (bench datapath model: dp_xout=dp_xin+(dp_sel+1), dp_yout=dp_yin-(dp_sel+1), dp_zout=dp_zin^dp_sel)
//  1 reset: assert rst_n=0 mid-RUN -> m_valid=0, busy=0 same cycle; after release s_ready=1, no stale result.
//  2 x=0x0010,y=0x0100,z=0x0003,tag=5,en=4'b1111 -> m_valid after 5 edges; m_x=0x001A, m_y=0x00F6, m_tag=5; dp_sel seq 0,1,2,3.
//  3 same operand, en=4'b0101 -> m_valid after 3 edges; dp_sel seq 0,2; m_x=0x0014, m_y=0x00FC.
//  4 en=4'b0000, x=0x1234 -> m_valid 1 edge after accept, m_x=0x1234, m_y=y unchanged.
//  5 m_ready=0 for 10 cycles in DONE -> m_* stable, s_ready=0; then m_ready=1 with s_valid=1 -> same-cycle retire+accept, no bubble.
//  6 stream 20 random operands, random m_ready/s_valid -> scoreboard order, tags, values match model; no loss or duplication.

Source files
------------

// File: rtl/hypercord_stage_sched_pkg.sv
// Shared types and helpers for the hyperbolic-CORDIC stage scheduler.
// first_set handles masks of up to 8 stages.
package hypercord_stage_sched_pkg;

   localparam int IDWIDTH       = 16;
   localparam int HC_NUM_STAGES = 4;

   typedef enum logic [1:0] {SCHED_IDLE, SCHED_RUN, SCHED_DONE} sched_state_t;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [2:0] first_set(input logic [7:0] mask);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hypercord_stage_ptr.sv
// Priority encoder: lowest enabled stage index plus an empty-mask flag.
module hypercord_stage_ptr
   import hypercord_stage_sched_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = 2
) (
   input  logic [N-1:0]    mask,
   output logic [SELW-1:0] idx,
   output logic            none
);

   logic [7:0] mask_w;

   always_comb begin
      mask_w         = '0;
      mask_w[N-1:0]  = mask;
   end

   assign idx  = SELW'(first_set(mask_w));
   assign none = (mask == '0);

endmodule

// File: rtl/hypercord_stage_sched.sv
// Time-multiplexes one shared CORDIC stage datapath over the enabled
// stages of each operand, with valid/ready ports on both sides.
//
//  state       | meaning
//  SCHED_IDLE  | no operand held, ready to accept
//  SCHED_RUN   | stepping through enabled stages, one per cycle
//  SCHED_DONE  | result presented on m_*, waiting for m_ready
module hypercord_stage_sched
   import hypercord_stage_sched_pkg::*;
#(
   parameter int DWIDTH     = IDWIDTH,
   parameter int NUM_STAGES = HC_NUM_STAGES,
   parameter int TAGW       = 4,
   localparam int SELW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DWIDTH-1:0]     s_x,
   input  logic [DWIDTH-1:0]     s_y,
   input  logic [DWIDTH-1:0]     s_z,
   input  logic [TAGW-1:0]       s_tag,
   input  logic [NUM_STAGES-1:0] cfg_stage_en,
   output logic [SELW-1:0]       dp_sel,
   output logic [DWIDTH-1:0]     dp_xin,
   output logic [DWIDTH-1:0]     dp_yin,
   output logic [DWIDTH-1:0]     dp_zin,
   input  logic [DWIDTH-1:0]     dp_xout,
   input  logic [DWIDTH-1:0]     dp_yout,
   input  logic [DWIDTH-1:0]     dp_zout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DWIDTH-1:0]     m_x,
   output logic [DWIDTH-1:0]     m_y,
   output logic [TAGW-1:0]       m_tag,
   output logic                  busy
);

   sched_state_t          state;
   logic [DWIDTH-1:0]     x_r, y_r, z_r;
   logic [TAGW-1:0]       tag_r;
   logic [NUM_STAGES-1:0] en_mask;
   logic [NUM_STAGES-1:0] mask_next;
   logic [SELW-1:0]       stage_ptr;
   logic [SELW-1:0]       acc_idx, adv_idx;
   logic                  acc_none, adv_none;
   logic                  acc;

   // Gated by rst_n so the source sees no ready while reset is held.
   assign s_ready   = rst_n & ((state == SCHED_IDLE) | ((state == SCHED_DONE) & m_ready));
   assign acc       = s_valid & s_ready;
   assign mask_next = en_mask & ~(NUM_STAGES'(1) << stage_ptr);

   hypercord_stage_ptr #(.N(NUM_STAGES), .SELW(SELW)) u_ptr_acc (
      .mask (cfg_stage_en),
      .idx  (acc_idx),
      .none (acc_none)
   );

   hypercord_stage_ptr #(.N(NUM_STAGES), .SELW(SELW)) u_ptr_adv (
      .mask (mask_next),
      .idx  (adv_idx),
      .none (adv_none)
   );

   // stage_ptr is parked at 0 outside RUN, so dp_sel needs no extra gating.
   assign dp_sel = stage_ptr;
   assign dp_xin = x_r;
   assign dp_yin = y_r;
   assign dp_zin = z_r;
   assign m_x    = x_r;
   assign m_y    = y_r;
   assign m_tag  = tag_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCHED_IDLE;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         tag_r     <= '0;
         en_mask   <= '0;
         stage_ptr <= '0;
         m_valid   <= 1'b0;
         busy      <= 1'b0;
      end else if (acc) begin
         x_r       <= s_x;
         y_r       <= s_y;
         z_r       <= s_z;
         tag_r     <= s_tag;
         en_mask   <= cfg_stage_en;
         stage_ptr <= acc_idx;
         state     <= acc_none ? SCHED_DONE : SCHED_RUN;
         m_valid   <= acc_none;
         busy      <= 1'b1;
      end else begin
         case (state)
            SCHED_RUN: begin
               x_r     <= dp_xout;
               y_r     <= dp_yout;
               // The final stage produces no Z, so the previous Z is kept.
               if (stage_ptr != SELW'(NUM_STAGES - 1)) z_r <= dp_zout;
               en_mask <= mask_next;
               if (adv_none) begin
                  state     <= SCHED_DONE;
                  stage_ptr <= '0;
                  m_valid   <= 1'b1;
               end else begin
                  stage_ptr <= adv_idx;
               end
            end
            SCHED_DONE: begin
               if (m_ready) begin
                  state   <= SCHED_IDLE;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hypercord_stage_sched.sv
// Self-checking bench: directed cases plus a random stream against a queue-based model.
module tb_hypercord_stage_sched;
   localparam int W = 16;
   localparam int N = 4;
   localparam int T = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_valid, s_ready;
   logic [W-1:0] s_x, s_y, s_z;
   logic [T-1:0] s_tag;
   logic [N-1:0] cfg_stage_en;
   logic [1:0]   dp_sel;
   logic [W-1:0] dp_xin, dp_yin, dp_zin, dp_xout, dp_yout, dp_zout;
   logic         m_valid, m_ready;
   logic [W-1:0] m_x, m_y;
   logic [T-1:0] m_tag;
   logic         busy;

   always #5 clk = ~clk;

   assign dp_xout = dp_xin + W'(dp_sel) + W'(1);
   assign dp_yout = dp_yin - W'(dp_sel) - W'(1);
   assign dp_zout = dp_zin ^ W'(dp_sel);

   hypercord_stage_sched dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_tag(s_tag),
      .cfg_stage_en(cfg_stage_en),
      .dp_sel(dp_sel), .dp_xin(dp_xin), .dp_yin(dp_yin), .dp_zin(dp_zin),
      .dp_xout(dp_xout), .dp_yout(dp_yout), .dp_zout(dp_zout),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_x(m_x), .m_y(m_y), .m_tag(m_tag),
      .busy(busy)
   );

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [T-1:0] tag;
   } res_t;

   res_t exp_q[$];
   int   sel_log[$];
   int   checks = 0;
   int   failures = 0;
   int   tx_cnt = 0;
   int   rx_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Each enabled stage i adds i+1 to X and subtracts i+1 from Y.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [T-1:0] tag, input logic [N-1:0] en);
      res_t r;
      r.x = x;
      r.y = y;
      r.tag = tag;
      for (int i = 0; i < N; i++) begin
         if (en[i]) begin
            r.x = r.x + W'(i + 1);
            r.y = r.y - W'(i + 1);
         end
      end
      return r;
   endfunction

   // Sample pre-edge handshakes, update scoreboard, then advance one clock.
   task automatic cyc();
      logic acc, ret, run;
      res_t r;
      #1;
      acc = s_valid && s_ready;
      ret = m_valid && m_ready;
      run = busy && !m_valid;
      if (rst_n) begin
         if (run) sel_log.push_back(int'(dp_sel));
         if (ret) begin
            if (exp_q.size() == 0) chk("spurious_result", 1, 0);
            else begin
               r = exp_q.pop_front();
               chk("out_x", 32'(m_x), 32'(r.x));
               chk("out_y", 32'(m_y), 32'(r.y));
               chk("out_tag", 32'(m_tag), 32'(r.tag));
            end
            rx_cnt++;
         end
         if (acc) begin
            exp_q.push_back(model(s_x, s_y, s_tag, cfg_stage_en));
            tx_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Accept one operand and wait (bounded) for its result; result left pending.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                        input logic [T-1:0] tag, input logic [N-1:0] en, input string nm);
      int lat;
      int k;
      sel_log.delete();
      s_valid = 1'b1; s_x = x; s_y = y; s_z = z; s_tag = tag; cfg_stage_en = en;
      m_ready = 1'b0;
      cyc();
      s_valid = 1'b0;
      cfg_stage_en = ~en;
      lat = 1;
      while (!m_valid && lat < 20) begin
         cyc();
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'($countones(en) + 1));
      chk({nm, "_sel_count"}, 32'(sel_log.size()), 32'($countones(en)));
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (en[i]) begin
            if (k < sel_log.size()) chk({nm, "_sel_seq"}, 32'(sel_log[k]), 32'(i));
            k++;
         end
      end
   endtask

   task automatic retire();
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] hold_x, hold_y;
      logic [T-1:0] hold_tag;
      int           n;

      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      s_x = '0; s_y = '0; s_z = '0; s_tag = '0; cfg_stage_en = '0;
      #2;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dp_sel", 32'(dp_sel), 0);
      chk("rst_m_x", 32'(m_x), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 1);

      do_op(16'h0010, 16'h0100, 16'h0003, 4'd5, 4'b1111, "all_en");
      chk("all_en_m_x", 32'(m_x), 32'h001A);
      chk("all_en_m_y", 32'(m_y), 32'h00F6);
      chk("all_en_m_tag", 32'(m_tag), 5);
      retire();

      do_op(16'h0010, 16'h0100, 16'h0003, 4'd6, 4'b0101, "en_0101");
      chk("en_0101_m_x", 32'(m_x), 32'h0014);
      chk("en_0101_m_y", 32'(m_y), 32'h00FC);
      retire();

      do_op(16'h1234, 16'h0055, 16'h0007, 4'd9, 4'b0000, "none_en");
      chk("none_en_m_x", 32'(m_x), 32'h1234);
      chk("none_en_m_y", 32'(m_y), 32'h0055);
      retire();
      chk("idle_after_retire", 32'(busy), 0);

      do_op(16'h0200, 16'h0300, 16'h0001, 4'd3, 4'b1111, "stall");
      hold_x = m_x; hold_y = m_y; hold_tag = m_tag;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("stall_m_valid", 32'(m_valid), 1);
         chk("stall_m_x", 32'(m_x), 32'(hold_x));
         chk("stall_m_y", 32'(m_y), 32'(hold_y));
         chk("stall_m_tag", 32'(m_tag), 32'(hold_tag));
         chk("stall_s_ready", 32'(s_ready), 0);
      end
      m_ready = 1'b1; s_valid = 1'b1;
      s_x = 16'h0040; s_y = 16'h0050; s_z = 16'h0002; s_tag = 4'd12; cfg_stage_en = 4'b0011;
      cyc();
      s_valid = 1'b0; m_ready = 1'b0;
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_m_valid", 32'(m_valid), 0);
      n = 0;
      while (!m_valid && n < 20) begin
         cyc();
         n++;
      end
      chk("b2b_latency", 32'(n + 1), 3);
      chk("b2b_m_x", 32'(m_x), 32'h0043);
      retire();

      // Reset while a result is waiting in DONE.
      do_op(16'h0001, 16'h0002, 16'h0003, 4'd1, 4'b0000, "rst_done");
      rst_n = 1'b0;
      #1;
      chk("rst_done_m_valid", 32'(m_valid), 0);
      chk("rst_done_busy", 32'(busy), 0);
      chk("rst_done_s_ready", 32'(s_ready), 0);
      exp_q.delete();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of RUN.
      s_valid = 1'b1; s_x = 16'h0777; s_y = 16'h0888; s_tag = 4'd2; cfg_stage_en = 4'b1111;
      cyc();
      s_valid = 1'b0;
      cyc();
      chk("mid_run_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", 32'(busy), 0);
      chk("rst_run_m_valid", 32'(m_valid), 0);
      chk("rst_run_dp_sel", 32'(dp_sel), 0);
      exp_q.delete();
      #1 rst_n = 1'b1;
      #1;
      chk("rst_run_s_ready", 32'(s_ready), 1);
      m_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (m_valid) n++;
      end
      chk("no_stale_result", 32'(n), 0);

      // Random stream: 20 operands with random valid/ready pressure.
      tx_cnt = 0; rx_cnt = 0;
      n = 0;
      while (rx_cnt < 20 && n < 3000) begin
         s_valid = (tx_cnt < 20) && ($urandom_range(0, 2) != 0);
         s_x = W'($urandom);
         s_y = W'($urandom);
         s_z = W'($urandom);
         s_tag = T'($urandom);
         cfg_stage_en = N'($urandom);
         m_ready = ($urandom_range(0, 3) != 0);
         cyc();
         n++;
      end
      s_valid = 1'b0;
      chk("rand_rx_count", 32'(rx_cnt), 20);
      chk("rand_tx_count", 32'(tx_cnt), 20);
      chk("rand_queue_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
